// File: rtl/ps2_key_seq_pkg.sv
// Shared state encoding and PS/2 Set-2 constants for the scan-code sequencer.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_LOOKUP,
        ST_WRITE
    } state_t;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] ASCII_NONE  = 8'hFF;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    // Only lowercase letters are folded; digits, punctuation and control bytes pass untouched.
    function automatic logic [7:0] apply_case(input logic [7:0] ch, input logic upper);
        if (upper && (ch >= 8'h61) && (ch <= 8'h7A))
            return ch - CASE_OFFSET;
        return ch;
    endfunction

endpackage

// File: rtl/ps2_key_seq_char_fifo.sv
// First-word-fall-through character FIFO; a push into a full FIFO succeeds only alongside a pop.
module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ps2_key_seq.sv
// Turns raw PS/2 Set-2 bytes into a character stream: strips E0/F0 prefixes,
// tracks Shift/CapsLock, consults the external negedge lookup and queues characters.
module ps2_key_seq
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter bit REPEAT_EN  = 1'b0
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          scan_valid,
    output logic                          scan_ready,
    input  logic [7:0]                    scan_code,
    output logic [7:0]                    key_code,
    input  logic [7:0]                    ascii_in,
    output logic [7:0]                    char_data,
    output logic                          char_valid,
    input  logic                          char_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          shift_on,
    output logic                          caps_on,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_key_code;
    logic [7:0] r_last_make;
    logic [7:0] r_char;
    logic       r_discard;
    logic       r_lshift;
    logic       r_rshift;
    logic       r_caps;
    logic       r_overflow;

    logic       w_accept;
    logic       w_make;
    logic       w_push;
    logic       w_full;
    logic       w_empty;

    assign scan_ready = (r_state == ST_IDLE) || (r_state == ST_EXT) ||
                        (r_state == ST_BRK)  || (r_state == ST_EXT_BRK);
    assign w_accept   = scan_valid & scan_ready;
    assign shift_on   = r_lshift | r_rshift;
    assign caps_on    = r_caps;
    assign key_code   = r_key_code;
    assign overflow   = r_overflow;
    assign char_valid = ~w_empty;
    assign w_push     = (r_state == ST_WRITE) & ~r_discard;

    // A "make" is any IDLE byte that is neither a prefix, a modifier, nor a suppressed repeat.
    always_comb begin
        w_make = 1'b1;
        if ((scan_code == SC_EXT) || (scan_code == SC_BREAK) ||
            (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT) || (scan_code == SC_CAPS))
            w_make = 1'b0;
        else if (!REPEAT_EN && (scan_code == r_last_make))
            w_make = 1'b0;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (scan_code == SC_EXT)
                        w_next = ST_EXT;
                    else if (scan_code == SC_BREAK)
                        w_next = ST_BRK;
                    else if (w_make)
                        w_next = ST_LOOKUP;
                end
            end
            ST_EXT: begin
                if (w_accept)
                    w_next = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
            end
            ST_BRK, ST_EXT_BRK: begin
                if (w_accept)
                    w_next = ST_IDLE;
            end
            ST_LOOKUP: w_next = ST_WRITE;
            ST_WRITE:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_key_code  <= '0;
            r_last_make <= '0;
            r_char      <= '0;
            r_discard   <= 1'b0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_caps      <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_accept) begin
                if (scan_code == SC_LSHIFT)
                    r_lshift <= 1'b1;
                else if (scan_code == SC_RSHIFT)
                    r_rshift <= 1'b1;
                else if (scan_code == SC_CAPS) begin
                    // Holding CapsLock auto-repeats 58; only the first make toggles.
                    if (r_last_make != SC_CAPS)
                        r_caps <= ~r_caps;
                    r_last_make <= SC_CAPS;
                end else if (w_make) begin
                    r_key_code  <= scan_code;
                    r_last_make <= scan_code;
                end
            end
            if ((r_state == ST_BRK) && w_accept) begin
                if (scan_code == SC_LSHIFT)
                    r_lshift <= 1'b0;
                if (scan_code == SC_RSHIFT)
                    r_rshift <= 1'b0;
                if (scan_code == r_last_make)
                    r_last_make <= '0;
            end
            if (r_state == ST_LOOKUP) begin
                r_char    <= apply_case(ascii_in, (r_lshift | r_rshift) ^ r_caps);
                r_discard <= (ascii_in == ASCII_NONE);
            end
        end
    end

    // Setting takes priority over clearing so a drop in the clear cycle is never lost.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_overflow <= 1'b0;
        else if (w_push && w_full && !char_ready)
            r_overflow <= 1'b1;
        else if (ovf_clr)
            r_overflow <= 1'b0;
    end

    char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .i_push  (w_push),
        .i_pop   (char_ready),
        .i_data  (r_char),
        .o_data  (char_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

endmodule

// File: tb/tb_ps2_key_seq.sv
// Self-checking bench for ps2_key_seq: directed scenarios plus randomized key events
// compared against a key-event-level model of the expected character stream.
module tb_ps2_key_seq;

    logic       clk;
    logic       clrn;
    logic       scan_valid;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic [7:0] key_code;
    logic [7:0] ascii_in;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic [3:0] fifo_count;
    logic       shift_on;
    logic       caps_on;
    logic       overflow;
    logic       ovf_clr;

    int tests = 0;
    int fails = 0;

    logic [7:0] expQ[$];
    bit         mLshift;
    bit         mRshift;
    bit         mCaps;
    logic [7:0] mLast;

    ps2_key_seq #(
        .FIFO_DEPTH (8),
        .REPEAT_EN  (1'b0)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .key_code   (key_code),
        .ascii_in   (ascii_in),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .fifo_count (fifo_count),
        .shift_on   (shift_on),
        .caps_on    (caps_on),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lut(input logic [7:0] sc);
        case (sc)
            8'h1C: return 8'h61;
            8'h32: return 8'h62;
            8'h21: return 8'h63;
            8'h23: return 8'h64;
            8'h24: return 8'h65;
            8'h2B: return 8'h66;
            8'h34: return 8'h67;
            8'h33: return 8'h68;
            8'h43: return 8'h69;
            8'h16: return 8'h31;
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            default: return 8'hFF;
        endcase
    endfunction

    // External scan-code to ASCII table, registered on the falling edge.
    initial ascii_in = 8'hFF;
    always @(negedge clk) ascii_in = lut(key_code);

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetModel();
        mLshift = 0;
        mRshift = 0;
        mCaps   = 0;
        mLast   = 8'h00;
        expQ.delete();
    endtask

    task automatic applyReset();
        scan_valid = 0;
        scan_code  = 0;
        char_ready = 0;
        ovf_clr    = 0;
        clrn       = 0;
        waitCycles(2);
        clrn = 1;
        waitCycles(1);
        resetModel();
    endtask

    // Presents one byte, holding it until accepted; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        while (scan_ready !== 1'b1 && n < 20) begin
            waitCycles(1);
            n++;
        end
        if (n >= 20)
            checkOutput("ready_timeout", {31'd0, scan_ready}, 32'd1);
        scan_valid = 1;
        scan_code  = b;
        @(posedge clk);
        #1;
        scan_valid = 0;
        scan_code  = 0;
    endtask

    task automatic keyMake(input logic [7:0] k);
        logic [7:0] a;
        applyStimulus(k);
        if (k == 8'h12) mLshift = 1;
        else if (k == 8'h59) mRshift = 1;
        else if (k == 8'h58) begin
            if (mLast != 8'h58) mCaps = !mCaps;
            mLast = 8'h58;
        end else if (k != mLast) begin
            mLast = k;
            a = lut(k);
            if (a != 8'hFF) begin
                if (a >= 8'h61 && a <= 8'h7A && ((mLshift | mRshift) ^ mCaps))
                    a = a - 8'h20;
                expQ.push_back(a);
            end
        end
    endtask

    task automatic keyBreak(input logic [7:0] k);
        applyStimulus(8'hF0);
        applyStimulus(k);
        if (k == 8'h12) mLshift = 0;
        if (k == 8'h59) mRshift = 0;
        if (k == mLast) mLast = 8'h00;
    endtask

    task automatic extMake(input logic [7:0] k);
        applyStimulus(8'hE0);
        applyStimulus(k);
    endtask

    task automatic extBreak(input logic [7:0] k);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(k);
    endtask

    task automatic drainCheck();
        logic [7:0] e;
        checkOutput("drain_count", 32'(fifo_count), 32'(expQ.size()));
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("drain_valid", {31'd0, char_valid}, 32'd1);
            checkOutput("drain_data", 32'(char_data), 32'(e));
            char_ready = 1;
            waitCycles(1);
            char_ready = 0;
        end
        checkOutput("drain_empty", {31'd0, char_valid}, 32'd0);
    endtask

    logic [7:0] randKeys [15] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h16,
                                  8'h29, 8'h5A, 8'h66, 8'h0E, 8'h12, 8'h59, 8'h58};
    logic [7:0] extKeys  [3]  = '{8'h75, 8'h6B, 8'h12};
    logic [7:0] fillKeys [9]  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

    initial begin
        clrn = 0;
        applyReset();

        checkOutput("rst_ready",   {31'd0, scan_ready}, 32'd1);
        checkOutput("rst_valid",   {31'd0, char_valid}, 32'd0);
        checkOutput("rst_count",   32'(fifo_count), 32'd0);
        checkOutput("rst_keycode", 32'(key_code), 32'd0);
        checkOutput("rst_data",    32'(char_data), 32'd0);
        checkOutput("rst_shift",   {31'd0, shift_on}, 32'd0);
        checkOutput("rst_caps",    {31'd0, caps_on}, 32'd0);
        checkOutput("rst_ovf",     {31'd0, overflow}, 32'd0);

        // Single make: latency of two edges from accept to char_valid.
        keyMake(8'h1C);
        checkOutput("lat_t0_valid", {31'd0, char_valid}, 32'd0);
        checkOutput("lat_keycode", 32'(key_code), 32'h1C);
        waitCycles(1);
        checkOutput("lat_t1_valid", {31'd0, char_valid}, 32'd0);
        waitCycles(1);
        checkOutput("lat_t2_valid", {31'd0, char_valid}, 32'd1);
        checkOutput("lat_t2_data", 32'(char_data), 32'h61);
        checkOutput("lat_t2_count", 32'(fifo_count), 32'd1);
        drainCheck();
        keyBreak(8'h1C);

        // Shifted letter, then shift released.
        keyMake(8'h12);
        keyMake(8'h1C);
        keyBreak(8'h1C);
        keyBreak(8'h12);
        checkOutput("shift_released", {31'd0, shift_on}, 32'd0);
        keyMake(8'h1C);
        keyBreak(8'h1C);
        waitCycles(3);
        checkOutput("shift_head", 32'(char_data), 32'h41);
        drainCheck();

        // CapsLock toggling, held-repeat immunity, and caps XOR shift.
        keyMake(8'h58);
        checkOutput("caps_on1", {31'd0, caps_on}, 32'd1);
        keyMake(8'h58);
        checkOutput("caps_held", {31'd0, caps_on}, 32'd1);
        keyBreak(8'h58);
        keyMake(8'h1C);
        keyBreak(8'h1C);
        keyMake(8'h59);
        checkOutput("rshift_on", {31'd0, shift_on}, 32'd1);
        keyMake(8'h1C);
        keyBreak(8'h1C);
        keyBreak(8'h59);
        keyMake(8'h58);
        checkOutput("caps_off", {31'd0, caps_on}, 32'd0);
        keyBreak(8'h58);
        waitCycles(3);
        checkOutput("caps_head", 32'(char_data), 32'h41);
        drainCheck();

        // Typematic repeat suppression, extended keys, control bytes, unmapped key.
        keyMake(8'h1C);
        keyMake(8'h1C);
        keyMake(8'h1C);
        keyBreak(8'h1C);
        keyMake(8'h1C);
        keyBreak(8'h1C);
        extMake(8'h75);
        extBreak(8'h75);
        waitCycles(3);
        checkOutput("repeat_count", 32'(fifo_count), 32'd2);
        checkOutput("ext_idle", {31'd0, scan_ready}, 32'd1);
        drainCheck();
        keyMake(8'h12);
        keyMake(8'h5A);
        keyMake(8'h66);
        keyMake(8'h29);
        keyMake(8'h0E);
        keyBreak(8'h12);
        waitCycles(3);
        checkOutput("ctrl_head", 32'(char_data), 32'h0D);
        drainCheck();

        // Fill to overflow, set-beats-clear, then push+pop while full.
        applyReset();
        for (int i = 0; i < 9; i++)
            applyStimulus(fillKeys[i]);
        waitCycles(3);
        checkOutput("full_count", 32'(fifo_count), 32'd8);
        checkOutput("full_ovf", {31'd0, overflow}, 32'd1);
        checkOutput("full_head", 32'(char_data), 32'h61);
        ovf_clr = 1;
        waitCycles(1);
        ovf_clr = 0;
        checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);
        applyStimulus(8'h29);
        waitCycles(1);
        ovf_clr = 1;
        waitCycles(1);
        ovf_clr = 0;
        checkOutput("ovf_set_wins", {31'd0, overflow}, 32'd1);
        ovf_clr = 1;
        waitCycles(1);
        ovf_clr = 0;
        checkOutput("ovf_cleared2", {31'd0, overflow}, 32'd0);
        applyStimulus(8'h16);
        waitCycles(1);
        char_ready = 1;
        waitCycles(1);
        char_ready = 0;
        checkOutput("pushpop_count", 32'(fifo_count), 32'd8);
        checkOutput("pushpop_ovf", {31'd0, overflow}, 32'd0);
        expQ = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h31};
        drainCheck();

        // Randomized key events against the event-level model.
        applyReset();
        for (int r = 0; r < 12; r++) begin
            for (int e = 0; e < 6; e++) begin
                int kind;
                kind = $urandom_range(0, 9);
                if (kind <= 5)
                    keyMake(randKeys[$urandom_range(0, 14)]);
                else if (kind <= 7)
                    keyBreak(randKeys[$urandom_range(0, 14)]);
                else if (kind == 8)
                    extMake(extKeys[$urandom_range(0, 2)]);
                else
                    extBreak(extKeys[$urandom_range(0, 2)]);
            end
            waitCycles(3);
            checkOutput("rand_shift", {31'd0, shift_on}, {31'd0, mLshift | mRshift});
            checkOutput("rand_caps", {31'd0, caps_on}, {31'd0, mCaps});
            checkOutput("rand_ovf", {31'd0, overflow}, 32'd0);
            drainCheck();
        end

        // Asynchronous reset in the middle of LOOKUP.
        applyReset();
        keyMake(8'h58);
        keyBreak(8'h58);
        keyMake(8'h12);
        keyMake(8'h32);
        waitCycles(3);
        checkOutput("pre_rst_count", 32'(fifo_count), 32'd1);
        applyStimulus(8'h1C);
        checkOutput("pre_rst_busy", {31'd0, scan_ready}, 32'd0);
        #1;
        clrn = 0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, char_valid}, 32'd0);
        checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
        checkOutput("mid_rst_data", 32'(char_data), 32'd0);
        checkOutput("mid_rst_keycode", 32'(key_code), 32'd0);
        checkOutput("mid_rst_shift", {31'd0, shift_on}, 32'd0);
        checkOutput("mid_rst_caps", {31'd0, caps_on}, 32'd0);
        checkOutput("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, scan_ready}, 32'd1);
        @(negedge clk);
        clrn = 1;
        resetModel();
        waitCycles(4);
        checkOutput("post_rst_valid", {31'd0, char_valid}, 32'd0);
        checkOutput("post_rst_count", 32'(fifo_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_seq.md
Name: ps2_key_seq

Overview:
- Sequences raw PS/2 Set-2 scan bytes into a character stream.
- Strips break (F0) and extended (E0) prefixes and tracks Shift/CapsLock state.
- Presents make codes to the existing scan-code→ASCII lookup (negedge-registered, 1-cycle), applies case, and buffers results in a small FIFO with a valid/ready output toward the text/display consumer.

Parameters:
FIFO_DEPTH, 8, character FIFO entries (power of 2, ≥2)
REPEAT_EN, 0, 1 = pass typematic repeats; 0 = suppress repeated make of held key

Ports:
clk  in  1  system clock; all state on posedge
clrn  in  1  asynchronous active-low reset
scan_valid  in  1  scan_code valid this cycle
scan_ready  out  1  high in IDLE/EXT/BRK/EXT_BRK; byte accepted when valid&ready
scan_code  in  8  raw PS/2 byte
key_code  out  8  make code driven to lookup
ascii_in  in  8  lookup result; FF = unmapped
char_data  out  8  FIFO head character
char_valid  out  1  FIFO non-empty
char_ready  in  1  consumer pop; pop when valid&ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
shift_on  out  1  either Shift held
caps_on  out  1  CapsLock toggled on
overflow  out  1  sticky: char dropped on full FIFO
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (clrn=0, async): state IDLE, key_code=00, FIFO empty, fifo_count=0, char_valid=0, shift_on=0, caps_on=0, overflow=0, last_make=00, lshift=rshift=0. char_data=00 when empty.
- FSM states: IDLE, EXT, BRK, EXT_BRK, LOOKUP, WRITE.
- IDLE: E0→EXT; F0→BRK; 12/59 → set lshift/rshift, stay.
- IDLE: 58 → toggle caps_on only if last_make≠58; set last_make=58.
- IDLE: any other byte → repeat check, then key_code<=byte, last_make<=byte, →LOOKUP.
- Repeat check: if REPEAT_EN=0 and byte==last_make, drop the byte and stay IDLE.
- BRK: 12/59 clear lshift/rshift; if byte==last_make, last_make<=00; →IDLE. No character generated.
- EXT: F0→EXT_BRK; any other byte → ignore, →IDLE.
- EXT_BRK: any byte → ignore, →IDLE.
- shift_on = lshift|rshift.
- LOOKUP (1 cycle): lookup registers key_code on the intervening negedge. At the posedge ending LOOKUP:
  - capture ascii_in into char_reg;
  - if char is a–z and (shift_on XOR caps_on), subtract 20h (uppercase);
  - if ascii_in==FF, mark discard.
  - →WRITE.
- WRITE (1 cycle): push char_reg unless discard; →IDLE.
- Latency: make accepted at edge T0 → char_valid high after edge T2 (FIFO was empty).
- scan_ready=0 in LOOKUP/WRITE; upstream must hold the byte.
- FIFO: first-word fall-through; char_data = head.
  - Push to full FIFO with no simultaneous pop: drop char, overflow<=1.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: set wins over ovf_clr in the same cycle.
- Control bytes from lookup (0D, 08, 20) pass through unmodified.

Decomposition:
- Package ps2_pkg:
  - state enum;
  - constants SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58, ASCII_NONE=FF, CASE_OFFSET=20h.
- Sub-module char_fifo (params WIDTH=8, DEPTH; push/pop/full/empty/count).
- Lookup stays external; ps2_key_seq connects to it via key_code/ascii_in.

Test Plan:
- Send 1C → lookup returns 61 → char_data=61 ("a"), char_valid rises 2 cycles after accept, fifo_count=1.
- Send 12, 1C, F0 1C, F0 12 → "A" (41) pushed; after the break sequence shift_on=0; next 1C yields 61.
- Send 58, F0 58, 58, F0 58 → caps_on 0→1→0; with caps on plus Shift held, 1C yields 61.
- REPEAT_EN=0: send 1C, 1C, 1C, F0 1C, 1C → exactly two 61 chars. Send E0 75 and E0 F0 75 → no chars; state returns to IDLE.
- char_ready=0, send 9 mapped makes with distinct keys and FIFO_DEPTH=8 → fifo_count=8, overflow=1, ninth char lost. Then pop-with-push while full → count stays 8, no new overflow. Pulse ovf_clr → overflow=0.
- Assert clrn=0 mid-LOOKUP → all outputs return to reset values immediately; no char pushed after release.
